alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_pkg.sv | 71 +++++++
 rtl/alu_op_decoder.sv | 58 +++++
 rtl/alu_exec_unit.sv | 126 ++++++++++++
 tb/tb_alu_exec_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_pkg
// Shared definitions for the MIPS execute-stage slice: ALU operation codes,
// instruction opcode/funct constants and the EXE/MEM register payload type.
// Optional build macro used by importers: ALU_VAR_SHIFT_EN (variable shifts).
// -----------------------------------------------------------------------------
package alu_exec_pkg;

  // 4-bit ALU operation encoding carried from Decode into Execute.
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_NOR  = 4'b0100,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1010,
    ALU_SLTU = 4'b1011,
    ALU_SLLV = 4'b1100,
    ALU_SRLV = 4'b1101,
    ALU_SRAV = 4'b1110
  } alu_op_t;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;

  // R-type function codes (instr[5:0]).
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // Everything the Memory and Write-back stages need from Execute.
  typedef struct packed {
    logic        syscall;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        mem_read;
    logic        load_full_word;
    logic        load_signed;
    logic [31:0] reg_data2;
    logic [31:0] alu_result;
    logic [4:0]  write_reg;
  } exe_mem_t;

endpackage

// File: rtl/alu_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
// Combinational ALU-operation decoder used in the Decode stage.
// Ports:
//   opcode_d  [5:0] in   instr[31:26]
//   funct_d   [5:0] in   instr[5:0]
//   alu_op_d  [3:0] out  ALU operation code (zero latency)
// Build macro: ALU_VAR_SHIFT_EN adds SLLV/SRLV/SRAV decoding.
// Anything not explicitly listed (including syscall) decodes to ADD so that
// loads, stores and unknown instructions compute a harmless sum.
// -----------------------------------------------------------------------------
module alu_op_decoder
  import alu_exec_pkg::*;
(
  input  logic [5:0] opcode_d,
  input  logic [5:0] funct_d,
  output logic [3:0] alu_op_d
);

  // Map opcode/funct to the ALU operation.
  always_comb begin
    alu_op_d = ALU_ADD;
    if (opcode_d == OPC_RTYPE) begin
      case (funct_d)
        FN_ADD, FN_ADDU: alu_op_d = ALU_ADD;
        FN_SUB, FN_SUBU: alu_op_d = ALU_SUB;
        FN_AND:          alu_op_d = ALU_AND;
        FN_OR:           alu_op_d = ALU_OR;
        FN_XOR:          alu_op_d = ALU_XOR;
        FN_NOR:          alu_op_d = ALU_NOR;
        FN_SLT:          alu_op_d = ALU_SLT;
        FN_SLTU:         alu_op_d = ALU_SLTU;
        FN_SLL:          alu_op_d = ALU_SLL;
        FN_SRL:          alu_op_d = ALU_SRL;
        FN_SRA:          alu_op_d = ALU_SRA;
`ifdef ALU_VAR_SHIFT_EN
        FN_SLLV:         alu_op_d = ALU_SLLV;
        FN_SRLV:         alu_op_d = ALU_SRLV;
        FN_SRAV:         alu_op_d = ALU_SRAV;
`endif
        default:         alu_op_d = ALU_ADD;
      endcase
    end else begin
      case (opcode_d)
        OPC_ADDI, OPC_ADDIU: alu_op_d = ALU_ADD;
        OPC_ANDI:            alu_op_d = ALU_AND;
        OPC_ORI:             alu_op_d = ALU_OR;
        OPC_XORI:            alu_op_d = ALU_XOR;
        OPC_SLTI:            alu_op_d = ALU_SLT;
        OPC_SLTIU:           alu_op_d = ALU_SLTU;
        OPC_BEQ, OPC_BNE:    alu_op_d = ALU_SUB;
        // Loads, stores and unlisted opcodes compute an address sum.
        default:             alu_op_d = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage slice of the 5-stage MIPS pipeline: ALU-op decoder (Decode),
// 32-bit combinational ALU (Execute) and the EXE/MEM pipeline register.
// Ports:
//   clk, reset_n                 clock, async active-low reset of EXE/MEM
//   opcode_d, funct_d -> alu_op_d     decoder (combinational)
//   alu_op_e, oprd1_e, oprd2_e, shamt_e -> alu_result_e, alu_zero_e  ALU
//   en                            EXE/MEM load enable (0 holds)
//   *_e controls, reg_data2_e, write_reg_e -> *_m registered outputs
// Build macro: ALU_VAR_SHIFT_EN enables SLLV/SRLV/SRAV (codes 1100-1110);
// without it those codes return 0.
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode_d,
  input  logic [5:0]  funct_d,
  output logic [3:0]  alu_op_d,
  input  logic [3:0]  alu_op_e,
  input  logic [31:0] oprd1_e,
  input  logic [31:0] oprd2_e,
  input  logic [4:0]  shamt_e,
  output logic [31:0] alu_result_e,
  output logic        alu_zero_e,
  input  logic        en,
  input  logic        syscall_e,
  input  logic        reg_write_e,
  input  logic        mem_to_reg_e,
  input  logic        mem_write_e,
  input  logic        mem_read_e,
  input  logic        load_full_word_e,
  input  logic        load_signed_e,
  input  logic [31:0] reg_data2_e,
  input  logic [4:0]  write_reg_e,
  output logic        syscall_m,
  output logic        reg_write_m,
  output logic        mem_to_reg_m,
  output logic        mem_write_m,
  output logic        mem_read_m,
  output logic        load_full_word_m,
  output logic        load_signed_m,
  output logic [31:0] reg_data2_m,
  output logic [31:0] alu_result_m,
  output logic [4:0]  write_reg_m
);

  exe_mem_t exe_mem_d;
  exe_mem_t exe_mem_q;

  alu_op_decoder u_alu_op_decoder (
    .opcode_d (opcode_d),
    .funct_d  (funct_d),
    .alu_op_d (alu_op_d)
  );

  // 32-bit ALU; unused codes return zero.
  always_comb begin
    alu_result_e = 32'd0;
    case (alu_op_e)
      ALU_AND:  alu_result_e = oprd1_e & oprd2_e;
      ALU_OR:   alu_result_e = oprd1_e | oprd2_e;
      ALU_ADD:  alu_result_e = oprd1_e + oprd2_e;
      ALU_XOR:  alu_result_e = oprd1_e ^ oprd2_e;
      ALU_NOR:  alu_result_e = ~(oprd1_e | oprd2_e);
      ALU_SUB:  alu_result_e = oprd1_e - oprd2_e;
      ALU_SLT:  alu_result_e = ($signed(oprd1_e) < $signed(oprd2_e)) ? 32'd1 : 32'd0;
      ALU_SLTU: alu_result_e = (oprd1_e < oprd2_e) ? 32'd1 : 32'd0;
      // Immediate shifts move oprd2 (rt) by the instruction's shamt field.
      ALU_SLL:  alu_result_e = oprd2_e << shamt_e;
      ALU_SRL:  alu_result_e = oprd2_e >> shamt_e;
      ALU_SRA:  alu_result_e = $unsigned($signed(oprd2_e) >>> shamt_e);
`ifdef ALU_VAR_SHIFT_EN
      // Variable shifts take the amount from rs, low five bits only.
      ALU_SLLV: alu_result_e = oprd2_e << oprd1_e[4:0];
      ALU_SRLV: alu_result_e = oprd2_e >> oprd1_e[4:0];
      ALU_SRAV: alu_result_e = $unsigned($signed(oprd2_e) >>> oprd1_e[4:0]);
`endif
      default:  alu_result_e = 32'd0;
    endcase
  end

  assign alu_zero_e = (alu_result_e == 32'd0);

  // Next EXE/MEM contents: load the Execute-stage bundle when enabled, else hold.
  always_comb begin
    exe_mem_d = exe_mem_q;
    if (en) begin
      exe_mem_d.syscall        = syscall_e;
      exe_mem_d.reg_write      = reg_write_e;
      exe_mem_d.mem_to_reg     = mem_to_reg_e;
      exe_mem_d.mem_write      = mem_write_e;
      exe_mem_d.mem_read       = mem_read_e;
      exe_mem_d.load_full_word = load_full_word_e;
      exe_mem_d.load_signed    = load_signed_e;
      exe_mem_d.reg_data2      = reg_data2_e;
      exe_mem_d.alu_result     = alu_result_e;
      exe_mem_d.write_reg      = write_reg_e;
    end else begin
      exe_mem_d = exe_mem_q;
    end
  end

  // EXE/MEM register; reset squashes the in-flight instruction (no write, no syscall).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exe_mem_q <= {$bits(exe_mem_t){1'b0}};
    end else begin
      exe_mem_q <= exe_mem_d;
    end
  end

  assign syscall_m        = exe_mem_q.syscall;
  assign reg_write_m      = exe_mem_q.reg_write;
  assign mem_to_reg_m     = exe_mem_q.mem_to_reg;
  assign mem_write_m      = exe_mem_q.mem_write;
  assign mem_read_m       = exe_mem_q.mem_read;
  assign load_full_word_m = exe_mem_q.load_full_word;
  assign load_signed_m    = exe_mem_q.load_signed;
  assign reg_data2_m      = exe_mem_q.reg_data2;
  assign alu_result_m     = exe_mem_q.alu_result;
  assign write_reg_m      = exe_mem_q.write_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed-vector bench for alu_exec_unit with an arithmetic reference model
// and a negedge compare process. Honours ALU_VAR_SHIFT_EN like the design.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  logic        clk;
  logic        reset_n;
  logic [5:0]  opcode_d, funct_d;
  logic [3:0]  alu_op_d, alu_op_e;
  logic [31:0] oprd1_e, oprd2_e;
  logic [4:0]  shamt_e;
  logic [31:0] alu_result_e;
  logic        alu_zero_e;
  logic        en;
  logic        syscall_e, reg_write_e, mem_to_reg_e, mem_write_e, mem_read_e;
  logic        load_full_word_e, load_signed_e;
  logic [31:0] reg_data2_e;
  logic [4:0]  write_reg_e;
  logic        syscall_m, reg_write_m, mem_to_reg_m, mem_write_m, mem_read_m;
  logic        load_full_word_m, load_signed_m;
  logic [31:0] reg_data2_m, alu_result_m;
  logic [4:0]  write_reg_m;

  int n_checks = 0;
  int n_errors = 0;
  logic cmp_en = 1'b0;

  // Expected EXE/MEM contents
  logic [31:0] exp_res, exp_rd2;
  logic [4:0]  exp_wr;
  logic [6:0]  exp_ctl;

  alu_exec_unit dut (
    .clk(clk), .reset_n(reset_n),
    .opcode_d(opcode_d), .funct_d(funct_d), .alu_op_d(alu_op_d),
    .alu_op_e(alu_op_e), .oprd1_e(oprd1_e), .oprd2_e(oprd2_e), .shamt_e(shamt_e),
    .alu_result_e(alu_result_e), .alu_zero_e(alu_zero_e),
    .en(en),
    .syscall_e(syscall_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .mem_write_e(mem_write_e), .mem_read_e(mem_read_e),
    .load_full_word_e(load_full_word_e), .load_signed_e(load_signed_e),
    .reg_data2_e(reg_data2_e), .write_reg_e(write_reg_e),
    .syscall_m(syscall_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .mem_write_m(mem_write_m), .mem_read_m(mem_read_m),
    .load_full_word_m(load_full_word_m), .load_signed_m(load_signed_m),
    .reg_data2_m(reg_data2_m), .alu_result_m(alu_result_m), .write_reg_m(write_reg_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference decoder written from the instruction tables.
  function automatic logic [3:0] m_dec(input logic [5:0] opc, input logic [5:0] fn);
    logic [3:0] r;
    r = 4'b0010;
    if (opc == 6'h00) begin
      if (fn == 6'h22 || fn == 6'h23) r = 4'b0110;
      if (fn == 6'h24) r = 4'b0000;
      if (fn == 6'h25) r = 4'b0001;
      if (fn == 6'h26) r = 4'b0011;
      if (fn == 6'h27) r = 4'b0100;
      if (fn == 6'h2A) r = 4'b0111;
      if (fn == 6'h2B) r = 4'b1011;
      if (fn == 6'h00) r = 4'b1000;
      if (fn == 6'h02) r = 4'b1001;
      if (fn == 6'h03) r = 4'b1010;
`ifdef ALU_VAR_SHIFT_EN
      if (fn == 6'h04) r = 4'b1100;
      if (fn == 6'h06) r = 4'b1101;
      if (fn == 6'h07) r = 4'b1110;
`endif
    end else begin
      if (opc == 6'h0C) r = 4'b0000;
      if (opc == 6'h0D) r = 4'b0001;
      if (opc == 6'h0E) r = 4'b0011;
      if (opc == 6'h0A) r = 4'b0111;
      if (opc == 6'h0B) r = 4'b1011;
      if (opc == 6'h04 || opc == 6'h05) r = 4'b0110;
    end
    return r;
  endfunction

  // Reference ALU: shifts via multiply/divide by powers of two, signed compare by sign bits.
  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    logic [31:0] p;
    logic        var_sh;
    var_sh = (op == 4'b1100 || op == 4'b1101 || op == 4'b1110);
    p = 32'd1 << (var_sh ? a[4:0] : sh);
    r = 32'd0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a ^ b;
      4'b0100: r = ~(a | b);
      4'b0110: r = a - b;
      4'b0111: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'b1011: r = {31'd0, (a < b)};
      4'b1000: r = b * p;
      4'b1001: r = b / p;
      4'b1010: r = b[31] ? ~((~b) / p) : b / p;
`ifdef ALU_VAR_SHIFT_EN
      4'b1100: r = b * p;
      4'b1101: r = b / p;
      4'b1110: r = b[31] ? ~((~b) / p) : b / p;
`endif
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the EXE/MEM register.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_res <= 32'd0; exp_rd2 <= 32'd0; exp_wr <= 5'd0; exp_ctl <= 7'd0;
    end else if (en) begin
      exp_res <= m_alu(alu_op_e, oprd1_e, oprd2_e, shamt_e);
      exp_rd2 <= reg_data2_e;
      exp_wr  <= write_reg_e;
      exp_ctl <= {syscall_e, reg_write_e, mem_to_reg_e, mem_write_e, mem_read_e,
                  load_full_word_e, load_signed_e};
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_alu_op_d", {28'd0, alu_op_d}, {28'd0, m_dec(opcode_d, funct_d)});
      check("cmp_alu_result_e", alu_result_e, m_alu(alu_op_e, oprd1_e, oprd2_e, shamt_e));
      check("cmp_alu_zero_e", {31'd0, alu_zero_e},
            {31'd0, (m_alu(alu_op_e, oprd1_e, oprd2_e, shamt_e) == 32'd0)});
      check("cmp_alu_result_m", alu_result_m, exp_res);
      check("cmp_reg_data2_m", reg_data2_m, exp_rd2);
      check("cmp_write_reg_m", {27'd0, write_reg_m}, {27'd0, exp_wr});
      check("cmp_ctl_m", {25'd0, syscall_m, reg_write_m, mem_to_reg_m, mem_write_m,
                          mem_read_m, load_full_word_m, load_signed_m}, {25'd0, exp_ctl});
    end
  end

  function automatic logic [31:0] ctl_m();
    return {25'd0, syscall_m, reg_write_m, mem_to_reg_m, mem_write_m, mem_read_m,
            load_full_word_m, load_signed_m};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
    alu_op_e = op; oprd1_e = a; oprd2_e = b; shamt_e = sh;
    #1;
  endtask

  task automatic set_ctl(input logic [6:0] c, input logic [31:0] rd2, input logic [4:0] wr);
    {syscall_e, reg_write_e, mem_to_reg_e, mem_write_e, mem_read_e,
     load_full_word_e, load_signed_e} = c;
    reg_data2_e = rd2; write_reg_e = wr;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1;
    opcode_d = 6'h00; funct_d = 6'h20;
    alu_op_e = 4'b0010; oprd1_e = 32'd0; oprd2_e = 32'd0; shamt_e = 5'd0;
    set_ctl(7'h7F, 32'hDEADBEEF, 5'd31);
    #12;
    // Reset state, even with all inputs active and clock running
    check("reset_alu_result_m", alu_result_m, 32'd0);
    check("reset_reg_data2_m", reg_data2_m, 32'd0);
    check("reset_write_reg_m", {27'd0, write_reg_m}, 32'd0);
    check("reset_ctl_m", ctl_m(), 32'd0);
    @(negedge clk);
    set_ctl(7'd0, 32'd0, 5'd0);
    reset_n = 1'b1;
    cmp_en = 1'b1;

    // Decoder / ALU directed vectors
    step();
    opcode_d = 6'h08; funct_d = 6'h00;
    set_alu(4'b0010, 32'd0, 32'hFFFFFFFD, 5'd0);
    check("dec_addi", {28'd0, alu_op_d}, 32'h2);
    check("add_result", alu_result_e, 32'hFFFFFFFD);
    check("add_zero", {31'd0, alu_zero_e}, 32'd0);

    step();
    opcode_d = 6'h00; funct_d = 6'h22;
    set_alu(4'b0110, 32'd5, 32'd2, 5'd0);
    check("dec_sub", {28'd0, alu_op_d}, 32'h6);
    check("sub_5_2", alu_result_e, 32'd3);
    set_alu(4'b0110, 32'd5, 32'd5, 5'd0);
    check("sub_5_5", alu_result_e, 32'd0);
    check("sub_zero", {31'd0, alu_zero_e}, 32'd1);

    step();
    funct_d = 6'h02;
    set_alu(4'b1001, 32'd0, 32'd5, 5'd1);
    check("dec_srl", {28'd0, alu_op_d}, 32'h9);
    check("srl_5_1", alu_result_e, 32'd2);
    set_alu(4'b1010, 32'd0, 32'h80000000, 5'd4);
    check("sra_neg", alu_result_e, 32'hF8000000);

    step();
    funct_d = 6'h0C;
    set_alu(4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0);
    check("dec_syscall_add", {28'd0, alu_op_d}, 32'h2);
    check("slt_neg", alu_result_e, 32'd1);
    set_alu(4'b1011, 32'hFFFFFFFF, 32'd1, 5'd0);
    check("sltu_big", alu_result_e, 32'd0);
    set_alu(4'b0100, 32'h0F0F0000, 32'h000000F0, 5'd0);
    check("nor", alu_result_e, 32'hF0F0FF0F);
    set_alu(4'b0101, 32'd7, 32'd9, 5'd0);
    check("unused_op", alu_result_e, 32'd0);

    // Variable-shift option
    step();
    funct_d = 6'h04;
    set_alu(4'b1100, 32'd3, 32'd1, 5'd0);
`ifdef ALU_VAR_SHIFT_EN
    check("dec_sllv", {28'd0, alu_op_d}, 32'hC);
    check("sllv_result", alu_result_e, 32'd8);
`else
    check("dec_sllv_off", {28'd0, alu_op_d}, 32'h2);
    check("sllv_off_result", alu_result_e, 32'd0);
`endif

    // Capture then hold
    step();
    en = 1'b1;
    set_ctl(7'b0100000, 32'h000000A5, 5'd9);
    set_alu(4'b0010, 32'd3, 32'd4, 5'd0);
    step();
    check("cap_alu_result_m", alu_result_m, 32'd7);
    check("cap_write_reg_m", {27'd0, write_reg_m}, 32'd9);
    check("cap_reg_write_m", {31'd0, reg_write_m}, 32'd1);
    check("cap_reg_data2_m", reg_data2_m, 32'h000000A5);
    en = 1'b0;
    set_ctl(7'b1011111, 32'h12345678, 5'd3);
    set_alu(4'b0010, 32'd10, 32'd20, 5'd0);
    step();
    step();
    check("hold_alu_result_m", alu_result_m, 32'd7);
    check("hold_write_reg_m", {27'd0, write_reg_m}, 32'd9);
    check("hold_ctl_m", ctl_m(), 32'h20);

    // Mid-cycle reset drops the in-flight instruction
    en = 1'b1;
    set_ctl(7'b1100000, 32'h0000BEEF, 5'd17);
    step();
    check("pre_reset_res_m", alu_result_m, 32'd30);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_res_m", alu_result_m, 32'd0);
    check("async_rst_ctl_m", ctl_m(), 32'd0);
    check("async_rst_wr_m", {27'd0, write_reg_m}, 32'd0);
    check("async_rst_rd2_m", reg_data2_m, 32'd0);
    step();
    check("rst_over_edge_ctl_m", ctl_m(), 32'd0);
    #2 reset_n = 1'b1;
    step();
    check("post_rst_res_m", alu_result_m, 32'd30);
    check("post_rst_ctl_m", ctl_m(), 32'h60);

    // Sweep: every ALU code over a few operand patterns (compare process checks)
    for (int op = 0; op < 16; op++) begin
      step();
      en = op[0] | op[2];
      set_ctl(op[6:0] ^ 7'h55, 32'd0 + op * 32'h01010101, op[4:0] + 5'd1);
      set_alu(op[3:0], 32'h00000005 + op, 32'h80F0000F ^ (op << 8), op[4:0] + 5'd3);
      step();
      set_alu(op[3:0], 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd31);
      step();
      set_alu(op[3:0], 32'hFFFFFFE4, 32'hC0000001, 5'd0);
    end

    // Sweep: decoder over all functs (R-type) and all opcodes
    en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      opcode_d = 6'h00; funct_d = i[5:0];
      step();
      opcode_d = i[5:0]; funct_d = 6'h2A;
    end

    step();
    step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
